// File: rtl/ascon_dec_fsm.sv
// Ascon-128 AEAD decryption controller: sequences init, AD absorption, CT processing,
// finalization and tag verification over the shared permutation datapath and FIFOs.
module ascon_dec_fsm #(
  parameter int ROUND_WIDTH   = 4,
  parameter int DataAddrWidth = 7,
  parameter int DelayWidth    = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     start_i,
  output logic                     ready_o,
  input  logic [DataAddrWidth-1:0] ad_blocks_i,
  input  logic [DataAddrWidth-1:0] ct_blocks_i,
  input  logic [DelayWidth-1:0]    delay_i,
  input  logic                     ad_empty_i,
  output logic                     ad_pop_o,
  output logic                     ad_flush_o,
  input  logic                     ct_empty_i,
  output logic                     ct_pop_o,
  output logic                     ct_flush_o,
  input  logic                     pt_full_i,
  output logic                     pt_push_o,
  output logic                     pt_flush_o,
  input  logic                     tag_match_i,
  output logic [ROUND_WIDTH-1:0]   rnd_o,
  output logic                     load_state_o,
  output logic                     sel_state_init_o,
  output logic                     sel_xor_init_o,
  output logic                     sel_ad_o,
  output logic                     sel_xor_ext_o,
  output logic                     sel_replace_ext_o,
  output logic                     sel_xor_dom_sep_o,
  output logic                     sel_xor_fin_o,
  output logic                     sel_xor_tag_o,
  output logic                     pt_valid_o,
  output logic                     tag_valid_o,
  output logic                     auth_ok_o
);

  typedef enum logic [4:0] {
    S_IDLE, S_START, S_WAIT_DELAY,
    S_INI_STA, S_INI_MID, S_INI_END,
    S_WAIT_AD, S_AD_STA, S_AD_MID, S_AD_END,
    S_WAIT_CT, S_CT_STA, S_CT_MID, S_CT_END,
    S_WAIT_LAST_CT, S_FIN_STA, S_FIN_MID, S_FIN_END,
    S_VERIFY, S_DONE
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [ROUND_WIDTH-1:0]   r_rnd;
  logic [DataAddrWidth-1:0] r_ad_cnt, r_ct_cnt;
  logic [DelayWidth-1:0]    r_timer;
  logic                     r_auth_ok;

  logic w_rnd_ld12, w_rnd_ld6, w_rnd_inc, w_cnt_init, w_ad_inc, w_ct_inc, w_timer_inc, w_auth_ld;
  logic w_lastm, w_last_ad, w_last_ct;
  logic [DataAddrWidth-1:0] w_ct_last_idx;
  state_t w_after_ad;

  // A CT count of zero still carries the padded final block.
  assign w_ct_last_idx = (ct_blocks_i == '0) ? '0 : ct_blocks_i - DataAddrWidth'(1);
  assign w_lastm       = (r_rnd == ROUND_WIDTH'(10));
  assign w_last_ad     = (r_ad_cnt == ad_blocks_i);
  assign w_last_ct     = (r_ct_cnt == w_ct_last_idx);
  assign w_after_ad    = w_last_ct ? S_WAIT_LAST_CT : S_WAIT_CT;

  assign rnd_o     = r_rnd;
  assign auth_ok_o = r_auth_ok;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rnd     <= '0;
      r_ad_cnt  <= '0;
      r_ct_cnt  <= '0;
      r_timer   <= '0;
      r_auth_ok <= 1'b0;
    end else begin
      if (w_rnd_ld12)     r_rnd <= '0;
      else if (w_rnd_ld6) r_rnd <= ROUND_WIDTH'(6);
      else if (w_rnd_inc) r_rnd <= r_rnd + ROUND_WIDTH'(1);

      if (w_cnt_init) begin
        r_ad_cnt <= '0;
        r_ct_cnt <= '0;
        r_timer  <= '0;
      end else begin
        if (w_ad_inc)    r_ad_cnt <= r_ad_cnt + DataAddrWidth'(1);
        if (w_ct_inc)    r_ct_cnt <= r_ct_cnt + DataAddrWidth'(1);
        if (w_timer_inc) r_timer  <= r_timer + DelayWidth'(1);
      end

      if (w_auth_ld) r_auth_ok <= tag_match_i;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_rnd_ld12        = 1'b0;
    w_rnd_ld6         = 1'b0;
    w_rnd_inc         = 1'b0;
    w_cnt_init        = 1'b0;
    w_ad_inc          = 1'b0;
    w_ct_inc          = 1'b0;
    w_timer_inc       = 1'b0;
    w_auth_ld         = 1'b0;
    ready_o           = 1'b0;
    ad_pop_o          = 1'b0;
    ad_flush_o        = 1'b0;
    ct_pop_o          = 1'b0;
    ct_flush_o        = 1'b0;
    pt_push_o         = 1'b0;
    pt_flush_o        = 1'b0;
    load_state_o      = 1'b0;
    sel_state_init_o  = 1'b0;
    sel_xor_init_o    = 1'b0;
    sel_ad_o          = 1'b0;
    sel_xor_ext_o     = 1'b0;
    sel_replace_ext_o = 1'b0;
    sel_xor_dom_sep_o = 1'b0;
    sel_xor_fin_o     = 1'b0;
    sel_xor_tag_o     = 1'b0;
    pt_valid_o        = 1'b0;
    tag_valid_o       = 1'b0;

    case (r_state)
      S_IDLE: begin
        ready_o    = 1'b1;
        ad_flush_o = 1'b1;
        ct_flush_o = 1'b1;
        pt_flush_o = 1'b1;
        if (start_i) w_state_nxt = S_START;
      end
      S_START: begin
        w_cnt_init  = 1'b1;
        w_rnd_ld12  = 1'b1;
        w_state_nxt = S_WAIT_DELAY;
      end
      S_WAIT_DELAY: begin
        w_timer_inc = 1'b1;
        if (r_timer == delay_i) w_state_nxt = S_INI_STA;
      end
      S_INI_STA: begin
        load_state_o     = 1'b1;
        sel_state_init_o = 1'b1;
        w_rnd_inc        = 1'b1;
        w_state_nxt      = S_INI_MID;
      end
      S_INI_MID: begin
        load_state_o = 1'b1;
        w_rnd_inc    = 1'b1;
        if (w_lastm) w_state_nxt = S_INI_END;
      end
      S_INI_END: begin
        load_state_o   = 1'b1;
        sel_xor_init_o = 1'b1;
        if (w_last_ad) begin
          sel_xor_dom_sep_o = 1'b1;
          w_state_nxt       = w_after_ad;
        end else begin
          w_state_nxt = S_WAIT_AD;
        end
      end
      S_WAIT_AD: begin
        w_rnd_ld6 = 1'b1;
        if (!ad_empty_i) w_state_nxt = S_AD_STA;
      end
      S_AD_STA: begin
        load_state_o  = 1'b1;
        sel_ad_o      = 1'b1;
        sel_xor_ext_o = 1'b1;
        ad_pop_o      = 1'b1;
        w_ad_inc      = 1'b1;
        w_rnd_inc     = 1'b1;
        w_state_nxt   = S_AD_MID;
      end
      S_AD_MID: begin
        load_state_o = 1'b1;
        w_rnd_inc    = 1'b1;
        if (w_lastm) w_state_nxt = S_AD_END;
      end
      S_AD_END: begin
        load_state_o = 1'b1;
        if (w_last_ad) begin
          sel_xor_dom_sep_o = 1'b1;
          w_state_nxt       = w_after_ad;
        end else begin
          w_state_nxt = S_WAIT_AD;
        end
      end
      S_WAIT_CT: begin
        w_rnd_ld6 = 1'b1;
        if (!ct_empty_i && !pt_full_i) w_state_nxt = S_CT_STA;
      end
      S_CT_STA: begin
        load_state_o      = 1'b1;
        sel_replace_ext_o = 1'b1;
        ct_pop_o          = 1'b1;
        pt_push_o         = 1'b1;
        pt_valid_o        = 1'b1;
        w_ct_inc          = 1'b1;
        w_rnd_inc         = 1'b1;
        w_state_nxt       = S_CT_MID;
      end
      S_CT_MID: begin
        load_state_o = 1'b1;
        w_rnd_inc    = 1'b1;
        if (w_lastm) w_state_nxt = S_CT_END;
      end
      S_CT_END: begin
        load_state_o = 1'b1;
        w_state_nxt  = w_last_ct ? S_WAIT_LAST_CT : S_WAIT_CT;
      end
      S_WAIT_LAST_CT: begin
        w_rnd_ld12 = 1'b1;
        if (!ct_empty_i && !pt_full_i) w_state_nxt = S_FIN_STA;
      end
      S_FIN_STA: begin
        load_state_o      = 1'b1;
        sel_replace_ext_o = 1'b1;
        sel_xor_fin_o     = 1'b1;
        ct_pop_o          = 1'b1;
        pt_push_o         = 1'b1;
        pt_valid_o        = 1'b1;
        w_rnd_inc         = 1'b1;
        w_state_nxt       = S_FIN_MID;
      end
      S_FIN_MID: begin
        load_state_o = 1'b1;
        w_rnd_inc    = 1'b1;
        if (w_lastm) w_state_nxt = S_FIN_END;
      end
      S_FIN_END: begin
        load_state_o  = 1'b1;
        sel_xor_tag_o = 1'b1;
        w_state_nxt   = S_VERIFY;
      end
      S_VERIFY: begin
        w_auth_ld   = 1'b1;
        // Unauthenticated plaintext must never leave the PT FIFO.
        pt_flush_o  = !tag_match_i;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        tag_valid_o = 1'b1;
        if (!start_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascon_dec_fsm.sv
// Randomized bench for ascon_dec_fsm: each run is scored against per-message totals
// derived from block counts, delay and tag outcome.
module tb_ascon_dec_fsm;
  localparam int RW = 4;
  localparam int AW = 7;
  localparam int DW = 16;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic          ready_o;
  logic [AW-1:0] ad_blocks_i = '0;
  logic [AW-1:0] ct_blocks_i = '0;
  logic [DW-1:0] delay_i = '0;
  logic          ad_empty_i = 1'b0, ad_pop_o, ad_flush_o;
  logic          ct_empty_i = 1'b0, ct_pop_o, ct_flush_o;
  logic          pt_full_i = 1'b0, pt_push_o, pt_flush_o;
  logic          tag_match_i = 1'b0;
  logic [RW-1:0] rnd_o;
  logic          load_state_o, sel_state_init_o, sel_xor_init_o, sel_ad_o, sel_xor_ext_o;
  logic          sel_replace_ext_o, sel_xor_dom_sep_o, sel_xor_fin_o, sel_xor_tag_o;
  logic          pt_valid_o, tag_valid_o, auth_ok_o;

  ascon_dec_fsm #(.ROUND_WIDTH(RW), .DataAddrWidth(AW), .DelayWidth(DW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .ready_o(ready_o),
    .ad_blocks_i(ad_blocks_i), .ct_blocks_i(ct_blocks_i), .delay_i(delay_i),
    .ad_empty_i(ad_empty_i), .ad_pop_o(ad_pop_o), .ad_flush_o(ad_flush_o),
    .ct_empty_i(ct_empty_i), .ct_pop_o(ct_pop_o), .ct_flush_o(ct_flush_o),
    .pt_full_i(pt_full_i), .pt_push_o(pt_push_o), .pt_flush_o(pt_flush_o),
    .tag_match_i(tag_match_i), .rnd_o(rnd_o), .load_state_o(load_state_o),
    .sel_state_init_o(sel_state_init_o), .sel_xor_init_o(sel_xor_init_o),
    .sel_ad_o(sel_ad_o), .sel_xor_ext_o(sel_xor_ext_o),
    .sel_replace_ext_o(sel_replace_ext_o), .sel_xor_dom_sep_o(sel_xor_dom_sep_o),
    .sel_xor_fin_o(sel_xor_fin_o), .sel_xor_tag_o(sel_xor_tag_o),
    .pt_valid_o(pt_valid_o), .tag_valid_o(tag_valid_o), .auth_ok_o(auth_ok_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_stall(input int pct);
    ad_empty_i = ($urandom_range(0, 99) < pct);
    ct_empty_i = ($urandom_range(0, 99) < pct);
    pt_full_i  = ($urandom_range(0, 99) < pct);
  endtask

  // One message. hold>0 forces pt_full_i high for that many cycles after init;
  // abort pulses reset in the cycle after the first CT pop.
  task automatic run(input int ad, input int ct, input int dly, input bit tm,
                     input int hold, input bit abort, input int stall_pct);
    int  ctn, start_cyc, init_cyc, drop_cyc, first_pop_cyc, hold_cnt;
    int  n_load, n_adpop, n_ctpop, n_push, n_dom, n_fin, n_tag, n_flush;
    bit  done, abort_armed;
    ctn = (ct == 0) ? 1 : ct;
    start_cyc = -1; init_cyc = -1; drop_cyc = -1; first_pop_cyc = -1; hold_cnt = 0;
    n_load = 0; n_adpop = 0; n_ctpop = 0; n_push = 0; n_dom = 0; n_fin = 0; n_tag = 0; n_flush = 0;
    done = 1'b0; abort_armed = 1'b0;

    @(negedge clk_i);
    ad_blocks_i = AW'(ad);
    ct_blocks_i = AW'(ct);
    delay_i     = DW'(dly);
    tag_match_i = tm;
    start_i     = 1'b1;
    drive_stall((hold > 0) ? 0 : stall_pct);

    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk_i);
      if (abort_armed) begin
        start_i = 1'b0;
        #2 rst_n_i = 1'b0;
        #1;
        check("rst_ready", ready_o, 1);
        check("rst_rnd", rnd_o, 0);
        check("rst_auth", auth_ok_o, 0);
        check("rst_pop_push", {ct_pop_o, pt_push_o, ad_pop_o}, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check("rst_idle_ready", ready_o, 1);
        return;
      end
      if (!ready_o && start_cyc < 0) start_cyc = cyc;
      if (sel_state_init_o && init_cyc < 0) init_cyc = cyc;
      n_load  += int'(load_state_o);
      n_dom   += int'(sel_xor_dom_sep_o);
      n_tag   += int'(sel_xor_tag_o);
      if (pt_flush_o && !ready_o) n_flush++;
      if (ad_pop_o) begin
        n_adpop++;
        check("ad_pop_while_empty", ad_empty_i, 0);
      end
      if (ct_pop_o || pt_push_o) begin
        n_ctpop += int'(ct_pop_o);
        n_push  += int'(pt_push_o);
        check("pop_eq_push", ct_pop_o, pt_push_o);
        check("pt_valid_with_push", pt_valid_o, pt_push_o);
        check("ct_pop_while_empty", ct_empty_i, 0);
        check("pt_push_while_full", pt_full_i, 0);
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        if (abort) abort_armed = 1'b1;
      end
      if (sel_xor_fin_o) begin
        n_fin++;
        check("fin_on_last_ct", n_ctpop, ctn);
      end
      if (tag_valid_o) begin
        done = 1'b1;
        check("auth_ok", auth_ok_o, tm);
      end else begin
        if (hold > 0 && sel_xor_init_o) begin
          hold_cnt   = hold;
          ct_empty_i = 1'b0;
          pt_full_i  = 1'b1;
        end else if (hold_cnt > 0) begin
          hold_cnt--;
          if (hold_cnt == 0) begin
            pt_full_i = 1'b0;
            drop_cyc  = cyc;
          end
        end else if (hold == 0) begin
          drive_stall(stall_pct);
        end
        if (start_cyc >= 0) start_i = 1'($urandom_range(0, 1));
      end
    end

    if (!done) begin
      check("timeout", 0, 1);
      return;
    end
    check("load_cycles", n_load, 24 + 6 * ad + 6 * (ctn - 1));
    check("ad_pops", n_adpop, ad);
    check("ct_pops", n_ctpop, ctn);
    check("pt_pushes", n_push, ctn);
    check("dom_sep_once", n_dom, 1);
    check("fin_once", n_fin, 1);
    check("xor_tag_once", n_tag, 1);
    check("pt_flush_busy", n_flush, tm ? 0 : 1);
    check("start_to_init", init_cyc - start_cyc, dly + 2);
    if (hold > 0) check("pop_after_unstall", first_pop_cyc, drop_cyc + 1);

    start_i = 1'b0;
    @(negedge clk_i);
    check("idle_ready", ready_o, 1);
    check("idle_flushes", {ad_flush_o, ct_flush_o, pt_flush_o}, 3'b111);
    check("idle_auth_hold", auth_ok_o, tm);
    @(negedge clk_i);
    check("auth_hold_2", auth_ok_o, tm);
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    check("reset_ready", ready_o, 1);
    check("reset_rnd", rnd_o, 0);
    check("reset_auth", auth_ok_o, 0);
    check("reset_flushes", {ad_flush_o, ct_flush_o, pt_flush_o}, 3'b111);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check("post_reset_ready", ready_o, 1);
    check("post_reset_load", load_state_o, 0);

    run(0, 1, 0, 1'b1, 0, 1'b0, 0);    // minimal message
    run(2, 3, 0, 1'b1, 0, 1'b0, 0);    // AD and multi-block CT
    run(0, 1, 5, 1'b1, 0, 1'b0, 0);    // start delay
    run(0, 2, 0, 1'b1, 10, 1'b0, 0);   // PT FIFO stall in wait_ct
    run(1, 1, 0, 1'b0, 0, 1'b0, 0);    // tag mismatch
    run(0, 0, 1, 1'b1, 0, 1'b0, 0);    // zero CT blocks acts as one
    run(0, 3, 0, 1'b1, 0, 1'b1, 0);    // reset during ct_mid
    run(1, 1, 0, 1'b1, 0, 1'b0, 0);    // recovery run
    for (int r = 0; r < 20; r++) begin
      run(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 8)),
          1'($urandom_range(0, 1)), 0, 1'b0, 30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
